fifo_burst_reader: RTL and testbench

Drains the 2048x32b synchronous line FIFO into fixed-length DDR write bursts. Sits directly downstream of the FIFO's read port. Tracks FIFO occupancy by snooping accepted writes, and issues a command (address + length) to the DDR write arbiter once a full burst is available. It then streams exactly that many words with valid/ready backpressure and advances a wrapping frame address.

---
 rtl/fifo_burst_reader.sv | 167 ++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Drains the line FIFO into fixed-length write bursts with a wrapping frame address.
// Optional BURST_FLUSH_EN adds a flush input that issues a partial burst of the current level.
//
// state | meaning
// IDLE  | waiting for a full burst (or flush) in the FIFO
// CMD   | presenting burst command, prefetching into skid buffer
// DATA  | streaming burst words to the write port
module fifo_burst_reader #(
    parameter int BURST_LEN = 64,
    parameter int ADDR_WIDTH = 28,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int FRAME_BURSTS = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_wr_ok,
    output logic                  fifo_rd_en,
    input  logic [31:0]           fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic                  frame_start,
`ifdef BURST_FLUSH_EN
    input  logic                  flush,
`endif
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [8:0]            cmd_len,
    output logic                  dat_valid,
    input  logic                  dat_ready,
    output logic [31:0]           dat_data,
    output logic                  dat_last,
    output logic [11:0]           level,
    output logic                  busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    localparam int IDX_W = $clog2(FRAME_BURSTS + 1);
    localparam logic [8:0]       FULL_LEN = 9'(BURST_LEN);
    localparam logic [11:0]      FULL_LVL = 12'(BURST_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BURSTS - 1);

    logic [1:0]       state;
    logic [8:0]       rd_cnt;
    logic [8:0]       sent_cnt;
    logic [31:0]      skid0;
    logic [31:0]      skid1;
    logic [1:0]       skid_cnt;
    logic             rd_pend;
    logic             frame_pend;
    logic [IDX_W-1:0] burst_idx;

    logic       pop;
    logic       last_hs;
    logic [1:0] occ;
    logic       start;
    logic [8:0] start_len;

    assign cmd_valid = (state == CMD);
    assign busy      = (state != IDLE);
    assign dat_valid = (state == DATA) && (skid_cnt != 2'd0);
    assign dat_data  = skid0;
    assign dat_last  = dat_valid && ((sent_cnt + 9'd1) == cmd_len);
    assign pop       = dat_valid & dat_ready;
    assign last_hs   = pop & dat_last;

    // A word leaving the skid buffer this cycle frees its slot, which keeps reads back-to-back.
    assign occ        = skid_cnt - {1'b0, pop} + {1'b0, rd_pend};
    assign fifo_rd_en = (state != IDLE) && (occ < 2'd2) && (rd_cnt != cmd_len) && !fifo_empty;

    always_comb begin
        start     = (level >= FULL_LVL);
        start_len = FULL_LEN;
`ifdef BURST_FLUSH_EN
        if (!start && flush && (level != 12'd0)) begin
            start     = 1'b1;
            start_len = level[8:0];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 12'd0;
        end else begin
            level <= level + 12'(fifo_wr_ok) - 12'(fifo_rd_en);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd_addr   <= BASE_ADDR;
            cmd_len    <= FULL_LEN;
            burst_idx  <= '0;
            frame_pend <= 1'b0;
            rd_cnt     <= 9'd0;
            sent_cnt   <= 9'd0;
        end else begin
            frame_pend <= frame_start | (frame_pend & (state != IDLE));
            if (state == IDLE) begin
                rd_cnt   <= 9'd0;
                sent_cnt <= 9'd0;
            end else begin
                rd_cnt   <= rd_cnt + 9'(fifo_rd_en);
                sent_cnt <= sent_cnt + 9'(pop);
            end
            case (state)
                IDLE: begin
                    if (frame_pend) begin
                        cmd_addr  <= BASE_ADDR;
                        burst_idx <= '0;
                    end
                    if (start) begin
                        cmd_len <= start_len;
                        state   <= CMD;
                    end
                end
                CMD: begin
                    if (cmd_ready) state <= DATA;
                end
                DATA: begin
                    if (last_hs) begin
                        state <= IDLE;
                        if (burst_idx == LAST_IDX) begin
                            cmd_addr  <= BASE_ADDR;
                            burst_idx <= '0;
                        end else begin
                            cmd_addr  <= cmd_addr + ADDR_WIDTH'({cmd_len, 2'b00});
                            burst_idx <= burst_idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid0    <= 32'd0;
            skid1    <= 32'd0;
            skid_cnt <= 2'd0;
            rd_pend  <= 1'b0;
        end else begin
            rd_pend <= fifo_rd_en;
            if (rd_pend && pop) begin
                if (skid_cnt == 2'd2) begin
                    skid0 <= skid1;
                    skid1 <= fifo_rd_data;
                end else begin
                    skid0 <= fifo_rd_data;
                end
            end else if (rd_pend) begin
                if (skid_cnt == 2'd0) skid0 <= fifo_rd_data;
                else                  skid1 <= fifo_rd_data;
                skid_cnt <= skid_cnt + 2'd1;
            end else if (pop) begin
                skid0    <= skid1;
                skid_cnt <= skid_cnt - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: behavioural FIFO, command/data scoreboards.
// Exercises the flush path only when BURST_FLUSH_EN is defined.
module tb_fifo_burst_reader;

    localparam int BURST_LEN    = 64;
    localparam int FRAME_BURSTS = 4;

    typedef struct {
        logic [27:0] addr;
        logic [8:0]  len;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        fifo_wr_ok = 1'b0;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data;
    logic        fifo_empty;
    logic        frame_start = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic [27:0] cmd_addr;
    logic [8:0]  cmd_len;
    logic        dat_valid;
    logic        dat_ready = 1'b1;
    logic [31:0] dat_data;
    logic        dat_last;
    logic [11:0] level;
    logic        busy;
`ifdef BURST_FLUSH_EN
    logic        flush = 1'b0;
`endif

    logic [31:0] wr_word = 32'd0;
    logic [31:0] fifo_mem[$];
    logic [31:0] exp_q[$];
    cmd_t        cmd_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int wr_seq   = 0;
    logic [27:0] model_addr = 28'd0;
    int          model_idx  = 0;

    int          word_cnt = 0;
    int          bursts_done = 0;
    int          rd_out = 0;
    int          bubbles = 0;
    int          last_bubbles = 0;
    bit          in_burst = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = 32'd0;
    int          cur_len = 0;

    fifo_burst_reader #(
        .BURST_LEN(BURST_LEN),
        .ADDR_WIDTH(28),
        .BASE_ADDR(28'd0),
        .FRAME_BURSTS(FRAME_BURSTS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fifo_wr_ok(fifo_wr_ok),
        .fifo_rd_en(fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .fifo_empty(fifo_empty),
        .frame_start(frame_start),
`ifdef BURST_FLUSH_EN
        .flush(flush),
`endif
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr),
        .cmd_len(cmd_len),
        .dat_valid(dat_valid),
        .dat_ready(dat_ready),
        .dat_data(dat_data),
        .dat_last(dat_last),
        .level(level),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line FIFO model: read data registered one cycle after fifo_rd_en.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem.delete();
            fifo_empty   <= 1'b1;
            fifo_rd_data <= 32'd0;
        end else begin
            if (fifo_rd_en && fifo_mem.size() > 0) fifo_rd_data <= fifo_mem.pop_front();
            if (fifo_wr_ok) fifo_mem.push_back(wr_word);
            fifo_empty <= (fifo_mem.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
            word_cnt   = 0;
            rd_out     = 0;
            in_burst   = 0;
            bubbles    = 0;
        end else begin
            cmd_t        e;
            logic [31:0] d;
            check("level_max", 64'(level <= 12'd2048), 64'd1);
            if (prev_stall) begin
                check("hold_valid", 64'(dat_valid), 64'd1);
                check("hold_data", 64'(dat_data), 64'(prev_data));
            end
            prev_stall = dat_valid && !dat_ready;
            prev_data  = dat_data;
            if (fifo_rd_en) rd_out++;
            if (dat_valid && dat_ready) rd_out--;
            if (busy) check("outstanding", 64'(rd_out <= 2), 64'd1);
            if (cmd_valid && cmd_ready) begin
                if (cmd_q.size() == 0) begin
                    check("cmd_unexpected", 64'd1, 64'd0);
                    cur_len = 0;
                end else begin
                    e = cmd_q.pop_front();
                    check("cmd_addr", 64'(cmd_addr), 64'(e.addr));
                    check("cmd_len", 64'(cmd_len), 64'(e.len));
                    cur_len = int'(e.len);
                end
                word_cnt = 0;
            end
            if (in_burst && dat_ready && !dat_valid) bubbles++;
            if (dat_valid && dat_ready) begin
                word_cnt++;
                in_burst = 1;
                if (exp_q.size() == 0) begin
                    check("dat_unexpected", 64'd1, 64'd0);
                end else begin
                    d = exp_q.pop_front();
                    check("dat_data", 64'(dat_data), 64'(d));
                end
                check("dat_last", 64'(dat_last), 64'(word_cnt == cur_len));
                if (dat_last) begin
                    bursts_done++;
                    last_bubbles = bubbles;
                    bubbles  = 0;
                    in_burst = 0;
                end
            end
        end
    end

    task automatic expect_cmd(input logic [8:0] len);
        cmd_q.push_back('{model_addr, len});
        model_addr = model_addr + 28'(len) * 28'd4;
        model_idx++;
        if (model_idx == FRAME_BURSTS) begin
            model_addr = 28'd0;
            model_idx  = 0;
        end
    endtask

    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            wr_word    = 32'hC0DE_0000 + 32'(wr_seq);
            wr_seq++;
            fifo_wr_ok = 1'b1;
            exp_q.push_back(wr_word);
        end
        @(posedge clk); #1;
        fifo_wr_ok = 1'b0;
    endtask

    task automatic wait_bursts(input int target, input int budget, input bit rnd);
        int n = 0;
        while (bursts_done < target && n < budget) begin
            @(posedge clk); #1;
            if (rnd) dat_ready = 1'($urandom_range(0, 1));
            n++;
        end
        dat_ready = 1'b1;
        check("burst_timeout", 64'(bursts_done >= target), 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd_en"}, 64'(fifo_rd_en), 64'd0);
        check({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
        check({tag, "_cmd_addr"}, 64'(cmd_addr), 64'd0);
        check({tag, "_cmd_len"}, 64'(cmd_len), 64'd64);
        check({tag, "_dat_valid"}, 64'(dat_valid), 64'd0);
        check({tag, "_dat_data"}, 64'(dat_data), 64'd0);
        check({tag, "_dat_last"}, 64'(dat_last), 64'd0);
        check({tag, "_level"}, 64'(level), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int b0;
        int n;
        #1 rst_n = 1'b0;
        #2 check_reset_values("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Full burst, everything ready.
        b0 = bursts_done;
        expect_cmd(9'd64);
        write_words(64);
        wait_bursts(b0 + 1, 1000, 0);
        check("t1_no_bubbles", 64'(last_bubbles), 64'd0);
        @(negedge clk);
        check("t1_level_zero", 64'(level), 64'd0);

        // 63 words must not trigger a command; the 64th does, one cycle later.
        b0 = bursts_done;
        expect_cmd(9'd64);
        write_words(63);
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (cmd_valid) n++;
        end
        check("t2_no_cmd_at_63", 64'(n), 64'd0);
        @(posedge clk); #1;
        wr_word    = 32'hC0DE_0000 + 32'(wr_seq);
        wr_seq++;
        fifo_wr_ok = 1'b1;
        exp_q.push_back(wr_word);
        @(posedge clk); #1;
        fifo_wr_ok = 1'b0;
        @(negedge clk);
        check("t2_level_64", 64'(level), 64'd64);
        check("t2_cmd_not_yet", 64'(cmd_valid), 64'd0);
        @(negedge clk);
        check("t2_cmd_rise", 64'(cmd_valid), 64'd1);
        wait_bursts(b0 + 1, 1000, 0);

        // Random backpressure.
        b0 = bursts_done;
        expect_cmd(9'd64);
        write_words(64);
        wait_bursts(b0 + 1, 3000, 1);

        // Remaining frame bursts, wrap, then a frame_start mid-DATA.
        b0 = bursts_done;
        expect_cmd(9'd64);
        write_words(64);
        wait_bursts(b0 + 1, 1000, 0);
        b0 = bursts_done;
        expect_cmd(9'd64);
        write_words(64);
        wait_bursts(b0 + 1, 1000, 0);
        b0 = bursts_done;
        expect_cmd(9'd64);
        write_words(64);
        n = 0;
        while (word_cnt < 10 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("t4_mid_burst_timeout", 64'(word_cnt >= 10), 64'd1);
        #1 frame_start = 1'b1;
        model_addr = 28'd0;
        model_idx  = 0;
        @(posedge clk); #1 frame_start = 1'b0;
        wait_bursts(b0 + 1, 1000, 0);
        b0 = bursts_done;
        expect_cmd(9'd64);
        write_words(64);
        wait_bursts(b0 + 1, 1000, 0);

        // Reset in the middle of a burst.
        expect_cmd(9'd64);
        write_words(64);
        n = 0;
        while (word_cnt < 30 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("t5_word30_timeout", 64'(word_cnt >= 30), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        exp_q.delete();
        cmd_q.delete();
        model_addr = 28'd0;
        model_idx  = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        b0 = bursts_done;
        expect_cmd(9'd64);
        write_words(64);
        wait_bursts(b0 + 1, 1000, 0);

`ifdef BURST_FLUSH_EN
        // Partial burst via flush, then flush with nothing buffered.
        b0 = bursts_done;
        expect_cmd(9'd10);
        write_words(10);
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        wait_bursts(b0 + 1, 500, 0);
        @(negedge clk);
        check("flush_level_zero", 64'(level), 64'd0);
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (cmd_valid) n++;
        end
        check("flush_empty_no_cmd", 64'(n), 64'd0);
        b0 = bursts_done;
        expect_cmd(9'd64);
        write_words(64);
        wait_bursts(b0 + 1, 1000, 0);
`endif

        repeat (5) @(posedge clk);
        check("exp_data_left", 64'(exp_q.size()), 64'd0);
        check("exp_cmd_left", 64'(cmd_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
